// File: rtl/adc16dv160_pkg.sv
// adc16dv160_pkg
//   Shared types and helpers for the ADC16DV160 receive-side capture slice.
//   - SAMPLE_W / LANES : sample width and number of DDR lanes
//   - cap_state_t      : capture FSM state encoding
//   - ddr_merge()      : rebuilds one sample from the falling/rising DDR bytes
package adc16dv160_pkg;

    localparam int SAMPLE_W = 16;
    localparam int LANES    = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2
    } cap_state_t;

    // Lane k carries odd bit 2k+1 on the falling phase and even bit 2k on the
    // rising phase. Flipping the MSB turns offset-binary into two's complement.
    function automatic logic [SAMPLE_W-1:0] ddr_merge(
        input logic [LANES-1:0] fall,
        input logic [LANES-1:0] rise,
        input logic             twos
    );
        logic [SAMPLE_W-1:0] w;
        w = {SAMPLE_W{1'b0}};
        for (int k = 0; k < LANES; k++) begin
            w[2*k+1] = fall[k];
            w[2*k]   = rise[k];
        end
        if (twos) begin
            w[SAMPLE_W-1] = ~w[SAMPLE_W-1];
        end else begin
            w[SAMPLE_W-1] = w[SAMPLE_W-1];
        end
        return w;
    endfunction

endpackage

// File: rtl/adc_sample_fifo.sv
// adc_sample_fifo
//   Synchronous first-word-fall-through FIFO. The head entry is visible on
//   pop_data whenever valid is high; pop consumes it at the clock edge.
//   Storage is cleared on reset so the read port shows zero after reset.
//   Ports:
//     clk, rst            : clock, synchronous active-high reset
//     push, push_data     : write request and data (ignored when full)
//     pop                 : consume head entry (ignored when empty)
//     pop_data, valid     : head entry and not-empty flag
//     occupancy           : number of stored entries (0..DEPTH)
module adc_sample_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_STEP   = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_STEP   = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_ZERO   = {(AW+1){1'b0}};
    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Qualify requests against the current fill level.
    always_comb begin
        push_ok_s = push && (count_r != FULL_COUNT);
        pop_ok_s  = pop  && (count_r != CNT_ZERO);
    end

    // Storage, pointers and occupancy; push and pop may happen together.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= CNT_ZERO;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PTR_STEP;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_STEP;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_STEP;
                2'b01:   count_r <= count_r - CNT_STEP;
                default: count_r <= count_r;
            endcase
        end
    end

    assign pop_data  = mem_r[rd_ptr_r];
    assign valid     = (count_r != CNT_ZERO);
    assign occupancy = count_r;

endmodule

// File: rtl/adc16dv160_capture.sv
// adc16dv160_capture
//   Rebuilds one 16-bit sample per clock from the ADC16DV160 DDR bytes,
//   captures a burst of num_samples samples into a small FIFO and streams
//   them out over AXI-Stream with tlast on the final sample.
//   Ports:
//     clk, rst               : ADC forwarded clock, synchronous active-high reset
//     d_fall, d_rise         : DDR byte pair from the input primitives
//     start, num_samples     : burst request and length (length 0 = empty burst)
//     busy, done             : burst in progress / completion pulse
//     overflow, drop_count   : sticky drop flag and saturating drop counter
//     m_tdata/m_tvalid/m_tready/m_tlast : AXI-Stream master
module adc16dv160_capture
    import adc16dv160_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter bit TWOS_COMP = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [LANES-1:0]    d_fall,
    input  logic [LANES-1:0]    d_rise,
    input  logic                start,
    input  logic [23:0]         num_samples,
    output logic                busy,
    output logic                done,
    output logic                overflow,
    output logic [15:0]         drop_count,
    output logic [SAMPLE_W-1:0] m_tdata,
    output logic                m_tvalid,
    input  logic                m_tready,
    output logic                m_tlast
);

    localparam int OCC_W = $clog2(DEPTH) + 1;
    // One slot is always held back so the final (tlast) sample can never be lost.
    localparam logic [OCC_W-1:0] OCC_RESERVE = OCC_W'(DEPTH - 1);

    logic [SAMPLE_W-1:0] s1_r;
    cap_state_t          state_r;
    logic [23:0]         cnt_r;
    logic [23:0]         n_last_r;
    logic                busy_r;
    logic                done_r;
    logic                overflow_r;
    logic [15:0]         drop_count_r;

    logic                offer_s;
    logic                is_final_s;
    logic                push_s;
    logic                drop_s;
    logic                last_hs_s;
    logic [OCC_W-1:0]    occ_s;
    logic [SAMPLE_W:0]   fifo_out_s;
    logic                fifo_valid_s;

    // Stage S1: free-running sample register, loaded every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r <= {SAMPLE_W{1'b0}};
        end else begin
            s1_r <= ddr_merge(d_fall, d_rise, TWOS_COMP);
        end
    end

    // Push/drop decision for the sample offered this cycle.
    always_comb begin
        offer_s    = (state_r == CAPTURE);
        is_final_s = offer_s && (cnt_r == n_last_r);
        last_hs_s  = (state_r == DRAIN) && fifo_valid_s && m_tready && fifo_out_s[SAMPLE_W];
        if (!offer_s) begin
            push_s = 1'b0;
            drop_s = 1'b0;
        end else if (is_final_s) begin
            push_s = 1'b1;
            drop_s = 1'b0;
        end else if (occ_s < OCC_RESERVE) begin
            push_s = 1'b1;
            drop_s = 1'b0;
        end else begin
            push_s = 1'b0;
            drop_s = 1'b1;
        end
    end

    // Burst control FSM with registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            cnt_r        <= 24'd0;
            n_last_r     <= 24'd0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            overflow_r   <= 1'b0;
            drop_count_r <= 16'd0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        if (num_samples != 24'd0) begin
                            state_r      <= CAPTURE;
                            n_last_r     <= num_samples - 24'd1;
                            cnt_r        <= 24'd0;
                            overflow_r   <= 1'b0;
                            drop_count_r <= 16'd0;
                            busy_r       <= 1'b1;
                        end else begin
                            // Empty burst: acknowledge without producing data.
                            done_r <= 1'b1;
                        end
                    end
                end
                CAPTURE: begin
                    // The counter advances on every offered sample, pushed or dropped.
                    cnt_r <= cnt_r + 24'd1;
                    if (drop_s) begin
                        overflow_r <= 1'b1;
                        if (drop_count_r != 16'hFFFF) begin
                            drop_count_r <= drop_count_r + 16'd1;
                        end
                    end
                    if (is_final_s) begin
                        state_r <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (last_hs_s) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    adc_sample_fifo #(
        .WIDTH (SAMPLE_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data ({is_final_s, s1_r}),
        .pop       (m_tready),
        .pop_data  (fifo_out_s),
        .valid     (fifo_valid_s),
        .occupancy (occ_s)
    );

    assign busy       = busy_r;
    assign done       = done_r;
    assign overflow   = overflow_r;
    assign drop_count = drop_count_r;
    assign m_tdata    = fifo_out_s[SAMPLE_W-1:0];
    assign m_tlast    = fifo_out_s[SAMPLE_W];
    assign m_tvalid   = fifo_valid_s;

endmodule

// File: tb/tb_adc16dv160_capture.sv
// tb_adc16dv160_capture
//   Self-checking bench: two instances (two's-complement and raw) share the
//   stimulus; expected beats are queued when samples are driven and checked
//   against whatever each instance presents on its stream port.
module tb_adc16dv160_capture;

    localparam int DEPTH = 16;

    typedef struct packed {
        logic [15:0] data;
        logic        last;
    } beat_t;

    typedef struct {
        logic [7:0]  fall;
        logic [7:0]  rise;
        logic [15:0] raw_exp;
        logic [15:0] tc_exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  d_fall = 8'd0;
    logic [7:0]  d_rise = 8'd0;
    logic        start = 1'b0;
    logic [23:0] num_samples = 24'd0;
    logic        m_tready = 1'b0;

    logic        busy, done, overflow, m_tvalid, m_tlast;
    logic [15:0] drop_count, m_tdata;
    logic        busy_raw, done_raw, overflow_raw, m_tvalid_raw, m_tlast_raw;
    logic [15:0] drop_count_raw, m_tdata_raw;

    int    total = 0;
    int    bad   = 0;
    beat_t q_tc[$];
    beat_t q_raw[$];
    vec_t  vecs[6];
    bit    stall_tc  = 1'b0;
    bit    stall_raw = 1'b0;

    adc16dv160_capture #(.DEPTH(DEPTH), .TWOS_COMP(1'b1)) dut (
        .clk(clk), .rst(rst), .d_fall(d_fall), .d_rise(d_rise),
        .start(start), .num_samples(num_samples),
        .busy(busy), .done(done), .overflow(overflow), .drop_count(drop_count),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast)
    );

    adc16dv160_capture #(.DEPTH(DEPTH), .TWOS_COMP(1'b0)) dut_raw (
        .clk(clk), .rst(rst), .d_fall(d_fall), .d_rise(d_rise),
        .start(start), .num_samples(num_samples),
        .busy(busy_raw), .done(done_raw), .overflow(overflow_raw), .drop_count(drop_count_raw),
        .m_tdata(m_tdata_raw), .m_tvalid(m_tvalid_raw), .m_tready(m_tready), .m_tlast(m_tlast_raw)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Odd sample bits travel on the falling byte, even bits on the rising byte.
    function automatic logic [7:0] odd_bits(input logic [15:0] v);
        logic [7:0] r;
        for (int k = 0; k < 8; k++) r[k] = v[2*k+1];
        return r;
    endfunction

    function automatic logic [7:0] even_bits(input logic [15:0] v);
        logic [7:0] r;
        for (int k = 0; k < 8; k++) r[k] = v[2*k];
        return r;
    endfunction

    // Stream monitor for the two's-complement instance.
    always @(negedge clk) begin
        if (rst) begin
            stall_tc = 1'b0;
        end else begin
            if (stall_tc) check("tc_tvalid_hold", 32'(m_tvalid), 32'd1);
            if (m_tvalid) begin
                if (q_tc.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL tc_unexpected_beat: data=0x%0h last=%0d", m_tdata, m_tlast);
                end else begin
                    check("tc_tdata", 32'(m_tdata), 32'(q_tc[0].data));
                    check("tc_tlast", 32'(m_tlast), 32'(q_tc[0].last));
                    if (m_tready) void'(q_tc.pop_front());
                end
            end
            stall_tc = m_tvalid && !m_tready;
        end
    end

    // Stream monitor for the raw instance.
    always @(negedge clk) begin
        if (rst) begin
            stall_raw = 1'b0;
        end else begin
            if (stall_raw) check("raw_tvalid_hold", 32'(m_tvalid_raw), 32'd1);
            if (m_tvalid_raw) begin
                if (q_raw.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL raw_unexpected_beat: data=0x%0h last=%0d", m_tdata_raw, m_tlast_raw);
                end else begin
                    check("raw_tdata", 32'(m_tdata_raw), 32'(q_raw[0].data));
                    check("raw_tlast", 32'(m_tlast_raw), 32'(q_raw[0].last));
                    if (m_tready) void'(q_raw.pop_front());
                end
            end
            stall_raw = m_tvalid_raw && !m_tready;
        end
    end

    // mode 0: table vectors, 1: ramp from 0, 2: random samples.
    task automatic run_burst(input int n, input int mode, input logic rdy_cap, input bit restart_mid);
        logic [15:0] v, rx, tx;
        logic [7:0]  f, r;
        beat_t       b;
        bit          keep;
        @(posedge clk); #1;
        m_tready = rdy_cap;
        for (int i = 0; i < n; i++) begin
            if (mode == 0) begin
                f = vecs[i].fall; r = vecs[i].rise; rx = vecs[i].raw_exp; tx = vecs[i].tc_exp;
            end else begin
                v  = (mode == 1) ? i[15:0] : 16'($urandom);
                f  = odd_bits(v);
                r  = even_bits(v);
                rx = v;
                tx = {~v[15], v[14:0]};
            end
            d_fall      = f;
            d_rise      = r;
            start       = (i == 0) || (restart_mid && i == 3);
            num_samples = (i == 0) ? n[23:0] : 24'd5;
            keep = rdy_cap || (i < DEPTH - 1) || (i == n - 1);
            if (keep) begin
                b.last = (i == n - 1);
                b.data = tx;
                q_tc.push_back(b);
                b.data = rx;
                q_raw.push_back(b);
            end
            @(posedge clk); #1;
            if (i == 0) begin
                check("busy_rise", 32'(busy), 32'd1);
                check("overflow_cleared", 32'(overflow), 32'd0);
                check("drop_cleared", 32'(drop_count), 32'd0);
            end
        end
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit rnd, input string name);
        bit seen = 1'b0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(posedge clk); #1;
            m_tready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            @(negedge clk);
            if (done) seen = 1'b1;
            else check("busy_held", 32'(busy), 32'd1);
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s: done not seen within %0d cycles", name, budget);
        end else begin
            check("busy_falls_with_done", 32'(busy), 32'd0);
            check("raw_done", 32'(done_raw), 32'd1);
            check("queue_drained_tc", 32'(q_tc.size()), 32'd0);
            check("queue_drained_raw", 32'(q_raw.size()), 32'd0);
            @(negedge clk);
            check("done_single_cycle", 32'(done), 32'd0);
        end
    endtask

    initial begin
        logic [15:0] v;
        beat_t       b;
        vecs[0] = '{8'h14, 8'h46, 16'h1234, 16'h9234};
        vecs[1] = '{8'h03, 8'h1C, 16'h015A, 16'h815A};
        vecs[2] = '{8'hFF, 8'h00, 16'hAAAA, 16'h2AAA};
        vecs[3] = '{8'h00, 8'hFF, 16'h5555, 16'hD555};
        vecs[4] = '{8'h80, 8'h00, 16'h8000, 16'h0000};
        vecs[5] = '{8'h00, 8'h01, 16'h0001, 16'h8001};

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_drop_count", 32'(drop_count), 32'd0);
        check("rst_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_tlast", 32'(m_tlast), 32'd0);
        check("rst_tdata", 32'(m_tdata), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single sample 0x1234, then the full vector table.
        run_burst(1, 0, 1'b1, 1'b0);
        wait_done(20, 1'b0, "single_done");
        check("single_overflow", 32'(overflow), 32'd0);
        run_burst(6, 0, 1'b1, 1'b0);
        wait_done(20, 1'b0, "table_done");

        // Ramp with a second start mid-burst that must be ignored.
        run_burst(8, 1, 1'b1, 1'b1);
        wait_done(20, 1'b0, "ramp_done");
        check("ramp_drop_count", 32'(drop_count), 32'd0);
        repeat (4) begin
            @(negedge clk);
            check("ramp_no_restart", 32'(busy), 32'd0);
        end

        // Overflow: sink stalled for the whole capture, stalls during drain.
        run_burst(40, 1, 1'b0, 1'b0);
        wait_done(200, 1'b1, "ovf_done");
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_drop_count", 32'(drop_count), 32'd24);
        check("ovf_drop_count_raw", 32'(drop_count_raw), 32'd24);
        check("ovf_flag_raw", 32'(overflow_raw), 32'd1);

        // Long random burst, sink ready during capture, random during drain.
        run_burst(1000, 2, 1'b1, 1'b0);
        wait_done(200, 1'b1, "long_done");
        check("long_drop_count", 32'(drop_count), 32'd0);
        check("long_overflow", 32'(overflow), 32'd0);

        // Empty burst: done the following cycle, no data.
        @(posedge clk); #1;
        m_tready    = 1'b1;
        start       = 1'b1;
        num_samples = 24'd0;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("empty_done", 32'(done), 32'd1);
        check("empty_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("empty_done_pulse", 32'(done), 32'd0);
        check("empty_no_beat", 32'(m_tvalid), 32'd0);

        // Reset in the middle of a stalled burst with five entries queued.
        @(posedge clk); #1;
        m_tready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            v           = 16'h0A00 + i[15:0];
            d_fall      = odd_bits(v);
            d_rise      = even_bits(v);
            start       = (i == 0);
            num_samples = 24'd20;
            b.last = 1'b0;
            b.data = {~v[15], v[14:0]};
            q_tc.push_back(b);
            b.data = v;
            q_raw.push_back(b);
            @(posedge clk); #1;
        end
        start = 1'b0;
        rst   = 1'b1;
        q_tc.delete();
        q_raw.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_tvalid", 32'(m_tvalid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_overflow", 32'(overflow), 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("midrst_no_done", 32'(done), 32'd0);
        end

        // A clean burst after the abandoned one.
        run_burst(4, 1, 1'b1, 1'b0);
        wait_done(20, 1'b0, "post_rst_done");

        repeat (3) @(negedge clk);
        check("final_queue_tc", 32'(q_tc.size()), 32'd0);
        check("final_queue_raw", 32'(q_raw.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
